// File: rtl/fmttrans_tile_ctrl_if.sv
// Config-write, status and vputy op bus of the format-transpose tile controller.
// master: host/vputy side, slave: fmttrans_tile_ctrl.
interface fmttrans_tile_ctrl_if #(
  parameter int unsigned REGMAP_ADDR_WTH = 8,
  parameter int unsigned REGMAP_DATA_WTH = 32,
  parameter int unsigned MRX_IND_WTH     = 5,
  parameter int unsigned MRX_ADDR_WTH    = 9,
  parameter int unsigned TILE_LOG2       = 3
);
  localparam int unsigned N = 1 << TILE_LOG2;

  logic [REGMAP_ADDR_WTH-1:0] regmap_ftrans__waddr_i;
  logic [REGMAP_DATA_WTH-1:0] regmap_ftrans__wdata_i;
  logic                       regmap_ftrans__we_i;
  logic                       regmap_ftrans__intr_o;
  logic                       regmap_ftrans__busy_o;
  logic                       vputy_ftransctl__rdy_i;
  logic [4:0]                 ftransctl_vputy__code_o;
  logic [MRX_IND_WTH-1:0]     ftransctl_vputy__mrs0_index_o;
  logic [MRX_ADDR_WTH-1:0]    ftransctl_vputy__mrs0_addr_o;
  logic [5:0]                 ftransctl_vputy__sv_code_o;
  logic [TILE_LOG2-1:0]       ftransctl_vputy__mtx_sel_h_o;
  logic [MRX_IND_WTH-1:0]     ftransctl_vputy__mrd_index_o;
  logic [MRX_ADDR_WTH-1:0]    ftransctl_vputy__mrd_addr_o;
  logic [N-1:0]               ftransctl_vputy__strobe_h_o;

  modport master (
    output regmap_ftrans__waddr_i, regmap_ftrans__wdata_i, regmap_ftrans__we_i, vputy_ftransctl__rdy_i,
    input  regmap_ftrans__intr_o, regmap_ftrans__busy_o, ftransctl_vputy__code_o,
           ftransctl_vputy__mrs0_index_o, ftransctl_vputy__mrs0_addr_o, ftransctl_vputy__sv_code_o,
           ftransctl_vputy__mtx_sel_h_o, ftransctl_vputy__mrd_index_o, ftransctl_vputy__mrd_addr_o,
           ftransctl_vputy__strobe_h_o
  );

  modport slave (
    input  regmap_ftrans__waddr_i, regmap_ftrans__wdata_i, regmap_ftrans__we_i, vputy_ftransctl__rdy_i,
    output regmap_ftrans__intr_o, regmap_ftrans__busy_o, ftransctl_vputy__code_o,
           ftransctl_vputy__mrs0_index_o, ftransctl_vputy__mrs0_addr_o, ftransctl_vputy__sv_code_o,
           ftransctl_vputy__mtx_sel_h_o, ftransctl_vputy__mrd_index_o, ftransctl_vputy__mrd_addr_o,
           ftransctl_vputy__strobe_h_o
  );
endinterface

// File: rtl/fmttrans_tile_ctrl.sv
// Format-transpose controller: walks NxN tiles from source to destination matrix-register rows.
// Optional abort (ctrl bit2) is compiled in when FTRANS_ABORT_EN is defined.
module fmttrans_tile_ctrl #(
  parameter int unsigned REGMAP_ADDR_WTH = 8,
  parameter int unsigned REGMAP_DATA_WTH = 32,
  parameter int unsigned MRX_IND_WTH     = 5,
  parameter int unsigned MRX_ADDR_WTH    = 9,
  parameter int unsigned TILE_LOG2       = 3,
  parameter int unsigned DRAIN_CYC       = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  fmttrans_tile_ctrl_if.slave bus
);
  localparam int unsigned N        = 1 << TILE_LOG2;
  localparam int unsigned WIDX_WTH = REGMAP_ADDR_WTH - 2;
  localparam int unsigned DCNT_WTH = $clog2(DRAIN_CYC + 1);
  localparam int unsigned LOC_WTH  = MRX_ADDR_WTH + MRX_IND_WTH;

  typedef enum logic [1:0] {ST_IDLE, ST_TRANS, ST_DRAIN, ST_DONE} state_t;

  state_t                     state_q, state_d;
  logic [REGMAP_DATA_WTH-1:0] step_q, step_sh;
  logic [15:0]                sect_num_q, sect_num_sh, sect_cnt_q;
  logic [LOC_WTH-1:0]         src_loc_q, src_loc_sh, dst_loc_q, dst_loc_sh;
  logic                       start_q, intr_q, busy_q;
  logic [TILE_LOG2-1:0]       sv_cnt_q, ld_cnt_q;
  logic [MRX_ADDR_WTH-1:0]    src_addr_q, src_base_q, dst_addr_q, dst_base_q;
  logic [MRX_ADDR_WTH-1:0]    src_base_nxt, dst_base_nxt;
  logic [DCNT_WTH-1:0]        drain_cnt_q;
  logic [N-1:0]               strobe_c;
  logic [WIDX_WTH-1:0]        widx;
  logic                       ctrl_we, start_req, clr_req, abort_req;
  logic                       issue_c, sv_wrap, ld_wrap, last_issue;
  logic                       unused_waddr;

  assign widx         = bus.regmap_ftrans__waddr_i[REGMAP_ADDR_WTH-1:2];
  assign unused_waddr = ^bus.regmap_ftrans__waddr_i[1:0];
  assign ctrl_we      = bus.regmap_ftrans__we_i && (widx == WIDX_WTH'(0));
  // A second start is refused until the current job (including its start pulse) has returned to idle
  assign start_req    = ctrl_we && bus.regmap_ftrans__wdata_i[0] && (state_q == ST_IDLE) && !start_q;
  assign clr_req      = ctrl_we && bus.regmap_ftrans__wdata_i[1];
`ifdef FTRANS_ABORT_EN
  assign abort_req    = ctrl_we && bus.regmap_ftrans__wdata_i[2] && (state_q == ST_TRANS);
`else
  assign abort_req    = 1'b0;
`endif

  assign issue_c      = (state_q == ST_TRANS) && bus.vputy_ftransctl__rdy_i;
  assign sv_wrap      = (sv_cnt_q == TILE_LOG2'(N - 1));
  assign ld_wrap      = sv_wrap && (ld_cnt_q == TILE_LOG2'(N - 1));
  assign last_issue   = ld_wrap && (sect_cnt_q == (sect_num_sh - 16'd1));
  assign src_base_nxt = src_base_q + MRX_ADDR_WTH'(step_sh[15:8]);
  assign dst_base_nxt = dst_base_q + MRX_ADDR_WTH'(step_sh[31:24]);

  // Live configuration registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q     <= '0;
      sect_num_q <= '0;
      src_loc_q  <= '0;
      dst_loc_q  <= '0;
    end else if (bus.regmap_ftrans__we_i) begin
      case (widx)
        WIDX_WTH'(1): step_q     <= bus.regmap_ftrans__wdata_i;
        WIDX_WTH'(2): sect_num_q <= bus.regmap_ftrans__wdata_i[15:0];
        WIDX_WTH'(3): src_loc_q  <= bus.regmap_ftrans__wdata_i[LOC_WTH-1:0];
        WIDX_WTH'(4): dst_loc_q  <= bus.regmap_ftrans__wdata_i[LOC_WTH-1:0];
        default: ;
      endcase
    end
  end

  // Job shadows, frozen for the lifetime of a job
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q     <= 1'b0;
      step_sh     <= '0;
      sect_num_sh <= '0;
      src_loc_sh  <= '0;
      dst_loc_sh  <= '0;
    end else begin
      start_q <= start_req;
      if (start_req) begin
        step_sh     <= step_q;
        sect_num_sh <= sect_num_q;
        src_loc_sh  <= src_loc_q;
        dst_loc_sh  <= dst_loc_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      intr_q      <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != ST_IDLE);
      drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + DCNT_WTH'(1) : '0;
      if (state_q == ST_DONE) intr_q <= 1'b1;
      else if (clr_req)       intr_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_q) state_d = (sect_num_sh == 16'd0) ? ST_DONE : ST_TRANS;
      ST_TRANS: if (abort_req || (issue_c && last_issue)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_q == DCNT_WTH'(DRAIN_CYC - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Tile walk: sv_cnt inner, ld_cnt middle, sect_cnt outer; everything holds when no op is issued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sv_cnt_q   <= '0;
      ld_cnt_q   <= '0;
      sect_cnt_q <= '0;
      src_addr_q <= '0;
      src_base_q <= '0;
      dst_addr_q <= '0;
      dst_base_q <= '0;
    end else if (state_q != ST_TRANS) begin
      sv_cnt_q   <= '0;
      ld_cnt_q   <= '0;
      sect_cnt_q <= '0;
      src_addr_q <= src_loc_sh[MRX_ADDR_WTH-1:0];
      src_base_q <= src_loc_sh[MRX_ADDR_WTH-1:0];
      dst_addr_q <= dst_loc_sh[MRX_ADDR_WTH-1:0];
      dst_base_q <= dst_loc_sh[MRX_ADDR_WTH-1:0];
    end else if (issue_c) begin
      sv_cnt_q <= sv_cnt_q + TILE_LOG2'(1);
      if (sv_wrap) ld_cnt_q <= ld_cnt_q + TILE_LOG2'(1);
      if (ld_wrap) begin
        sect_cnt_q <= sect_cnt_q + 16'd1;
        src_base_q <= src_base_nxt;
        src_addr_q <= src_base_nxt;
        dst_base_q <= dst_base_nxt;
        dst_addr_q <= dst_base_nxt;
      end else if (sv_wrap) begin
        src_addr_q <= src_addr_q + MRX_ADDR_WTH'(step_sh[7:0]);
        dst_addr_q <= dst_base_q;
      end else begin
        dst_addr_q <= dst_addr_q + MRX_ADDR_WTH'(step_sh[23:16]);
      end
    end
  end

  always_comb begin
    strobe_c           = '0;
    strobe_c[ld_cnt_q] = 1'b1;
  end

  assign bus.regmap_ftrans__intr_o         = intr_q;
  assign bus.regmap_ftrans__busy_o         = busy_q;
  assign bus.ftransctl_vputy__code_o       = {4'b0000, issue_c};
  assign bus.ftransctl_vputy__sv_code_o    = {4'b0000, 1'b1, issue_c};
  assign bus.ftransctl_vputy__mrs0_index_o = src_loc_sh[LOC_WTH-1:MRX_ADDR_WTH];
  assign bus.ftransctl_vputy__mrs0_addr_o  = src_addr_q;
  assign bus.ftransctl_vputy__mrd_index_o  = dst_loc_sh[LOC_WTH-1:MRX_ADDR_WTH];
  assign bus.ftransctl_vputy__mrd_addr_o   = dst_addr_q;
  assign bus.ftransctl_vputy__mtx_sel_h_o  = sv_cnt_q;
  assign bus.ftransctl_vputy__strobe_h_o   = strobe_c;
endmodule

// File: tb/tb_fmttrans_tile_ctrl.sv
// Bench for fmttrans_tile_ctrl: job table + random jobs checked against an arithmetic tile-walk model.
module tb_fmttrans_tile_ctrl;
  localparam int unsigned RA = 8, RD = 32, IW = 5, AW = 9, TL = 3, DC = 8;
  localparam int unsigned N     = 1 << TL;
  localparam int unsigned AMASK = (1 << AW) - 1;
  localparam int          NONE  = -100;

  typedef struct {
    int unsigned sect, src, sstep, ssect, sidx, dst, dstep, dsect, didx;
    int          rdy_mode, abort_k, restart_k;
    bit          clr_at_done;
    int          exp_issues, exp_intr_k;
  } job_t;

  typedef struct { int job; int n; int unsigned src, dst, strobe, mtx; } spot_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_cmp = 0, n_bad = 0;
  logic [AW-1:0] obs_src [256];
  logic [AW-1:0] obs_dst [256];
  logic [N-1:0]  obs_stb [256];
  logic [TL-1:0] obs_mtx [256];
  job_t  jobs[$];
  spot_t spots[$];

  fmttrans_tile_ctrl_if #(.REGMAP_ADDR_WTH(RA), .REGMAP_DATA_WTH(RD), .MRX_IND_WTH(IW),
                          .MRX_ADDR_WTH(AW), .TILE_LOG2(TL)) bus ();

  fmttrans_tile_ctrl #(.REGMAP_ADDR_WTH(RA), .REGMAP_DATA_WTH(RD), .MRX_IND_WTH(IW),
                       .MRX_ADDR_WTH(AW), .TILE_LOG2(TL), .DRAIN_CYC(DC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int unsigned widx, input logic [31:0] d);
    bus.regmap_ftrans__waddr_i = RA'(widx * 4);
    bus.regmap_ftrans__wdata_i = d;
    bus.regmap_ftrans__we_i    = 1'b1;
    @(posedge clk_i); #1;
    bus.regmap_ftrans__we_i    = 1'b0;
  endtask

  function automatic job_t mk(int unsigned sect, int unsigned src, int unsigned sstep, int unsigned ssect,
                              int unsigned dst, int unsigned dstep, int unsigned dsect, int rdy_mode,
                              int abort_k, int restart_k, bit clr_at_done, int exp_issues, int exp_intr_k);
    job_t j;
    j.sect = sect; j.src = src; j.sstep = sstep; j.ssect = ssect; j.sidx = 3;
    j.dst = dst; j.dstep = dstep; j.dsect = dsect; j.didx = 7;
    j.rdy_mode = rdy_mode; j.abort_k = abort_k; j.restart_k = restart_k; j.clr_at_done = clr_at_done;
    j.exp_issues = exp_issues; j.exp_intr_k = exp_intr_k;
    return j;
  endfunction

  function automatic spot_t sp(int job, int n, int unsigned src, int unsigned dst, int unsigned stb,
                               int unsigned mtx);
    spot_t s;
    s.job = job; s.n = n; s.src = src; s.dst = dst; s.strobe = stb; s.mtx = mtx;
    return s;
  endfunction

  // Issue n of a job in closed form: section s, row l, column v
  function automatic void model_issue(input job_t j, input int unsigned n, output logic [AW-1:0] es,
                                      output logic [AW-1:0] ed, output logic [N-1:0] estb,
                                      output logic [TL-1:0] emtx);
    int unsigned s, l, v;
    s = n / (N * N); l = (n / N) % N; v = n % N;
    es   = AW'((j.src + s * j.ssect + l * j.sstep) & AMASK);
    ed   = AW'((j.dst + s * j.dsect + v * j.dstep) & AMASK);
    estb = N'(1) << l;
    emtx = TL'(v);
  endfunction

  task automatic run_job(input job_t j, input int ji);
    int unsigned   n_exp, n_dut, total;
    int            intr_k, rise_k;
    bit            ended, rdy, exp_iss;
    logic [AW-1:0] es, ed;
    logic [N-1:0]  estb;
    logic [TL-1:0] emtx;
    total = j.sect * N * N;
    wr(1, {8'(j.dsect), 8'(j.dstep), 8'(j.ssect), 8'(j.sstep)});
    wr(2, 32'(j.sect));
    wr(3, 32'((j.sidx << AW) | j.src));
    wr(4, 32'((j.didx << AW) | j.dst));
    bus.regmap_ftrans__waddr_i = '0;
    bus.regmap_ftrans__wdata_i = 32'h1;
    bus.regmap_ftrans__we_i    = 1'b1;
    @(negedge clk_i);
    chk($sformatf("j%0d busy_at_write", ji), bus.regmap_ftrans__busy_o, 0);
    @(posedge clk_i); #1;
    n_exp = 0; n_dut = 0; rise_k = NONE;
    ended  = (j.sect == 0);
    intr_k = (j.sect == 0) ? 1 : NONE;
    for (int k = -1; k < 3000; k++) begin
      case (j.rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(k >= 3 && k <= 5);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.vputy_ftransctl__rdy_i = rdy;
      bus.regmap_ftrans__we_i    = 1'b0;
      bus.regmap_ftrans__waddr_i = '0;
      if (k == j.restart_k) begin
        bus.regmap_ftrans__we_i = 1'b1; bus.regmap_ftrans__waddr_i = RA'(12);
        bus.regmap_ftrans__wdata_i = 32'h3FFF;
      end else if (k == j.restart_k + 1) begin
        bus.regmap_ftrans__we_i = 1'b1; bus.regmap_ftrans__wdata_i = 32'h1;
      end else if (k == j.abort_k) begin
        bus.regmap_ftrans__we_i = 1'b1; bus.regmap_ftrans__wdata_i = 32'h4;
      end else if (j.clr_at_done && intr_k != NONE && k == intr_k - 1) begin
        bus.regmap_ftrans__we_i = 1'b1; bus.regmap_ftrans__wdata_i = 32'h2;
      end
      @(negedge clk_i);
      exp_iss = (k >= 0) && !ended && rdy;
      if (k >= 0 && !ended) begin
        model_issue(j, n_exp, es, ed, estb, emtx);
        chk($sformatf("j%0d k%0d src_addr", ji, k), bus.ftransctl_vputy__mrs0_addr_o, es);
        chk($sformatf("j%0d k%0d dst_addr", ji, k), bus.ftransctl_vputy__mrd_addr_o, ed);
        chk($sformatf("j%0d k%0d strobe", ji, k), bus.ftransctl_vputy__strobe_h_o, estb);
        chk($sformatf("j%0d k%0d mtx_sel", ji, k), bus.ftransctl_vputy__mtx_sel_h_o, emtx);
        chk($sformatf("j%0d k%0d indices", ji, k),
            {bus.ftransctl_vputy__mrs0_index_o, bus.ftransctl_vputy__mrd_index_o}, {IW'(j.sidx), IW'(j.didx)});
      end
      chk($sformatf("j%0d k%0d code", ji, k), bus.ftransctl_vputy__code_o, 5'(exp_iss));
      chk($sformatf("j%0d k%0d sv_code", ji, k), bus.ftransctl_vputy__sv_code_o, 6'(2 + exp_iss));
      if (bus.ftransctl_vputy__code_o[0]) begin
        if (n_dut < 256) begin
          obs_src[n_dut] = bus.ftransctl_vputy__mrs0_addr_o;
          obs_dst[n_dut] = bus.ftransctl_vputy__mrd_addr_o;
          obs_stb[n_dut] = bus.ftransctl_vputy__strobe_h_o;
          obs_mtx[n_dut] = bus.ftransctl_vputy__mtx_sel_h_o;
        end
        n_dut++;
      end
      if (exp_iss) n_exp++;
      if (!ended && ((exp_iss && n_exp == total) || k == j.abort_k)) begin
        ended  = 1'b1;
        intr_k = k + DC + 2;
      end
      chk($sformatf("j%0d k%0d intr", ji, k), bus.regmap_ftrans__intr_o, (intr_k != NONE && k >= intr_k));
      chk($sformatf("j%0d k%0d busy", ji, k), bus.regmap_ftrans__busy_o,
          (k >= 0 && (intr_k == NONE || k < intr_k)));
      if (rise_k == NONE && bus.regmap_ftrans__intr_o) rise_k = k;
      @(posedge clk_i); #1;
      if (intr_k != NONE && k >= intr_k + 1) break;
    end
    chk($sformatf("j%0d job_ended", ji), ended, 1);
    chk($sformatf("j%0d issue_count", ji), n_dut, j.exp_issues);
    if (j.exp_intr_k != NONE) chk($sformatf("j%0d intr_cycle", ji), rise_k, j.exp_intr_k);
    foreach (spots[i]) begin
      if (spots[i].job == ji) begin
        chk($sformatf("j%0d spot%0d src", ji, spots[i].n), obs_src[spots[i].n], spots[i].src);
        chk($sformatf("j%0d spot%0d dst", ji, spots[i].n), obs_dst[spots[i].n], spots[i].dst);
        chk($sformatf("j%0d spot%0d strobe", ji, spots[i].n), obs_stb[spots[i].n], spots[i].strobe);
        chk($sformatf("j%0d spot%0d mtx", ji, spots[i].n), obs_mtx[spots[i].n], spots[i].mtx);
      end
    end
    wr(0, 32'h2);
    @(negedge clk_i);
    chk($sformatf("j%0d intr_cleared", ji), bus.regmap_ftrans__intr_o, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1;
    bus.regmap_ftrans__we_i    = 1'b0;
    bus.regmap_ftrans__waddr_i = '0;
    bus.regmap_ftrans__wdata_i = '0;
    bus.vputy_ftransctl__rdy_i = 1'b1;

    //          sect src    ss ssect  dst    ds dsect mode abort  restart clr  issues intr
    jobs.push_back(mk(1, 'h010, 1, 'h00, 'h100, 2, 'h00, 0, NONE, NONE, 0, 64, 73));
    jobs.push_back(mk(2, 'h010, 1, 'h40, 'h100, 2, 'h20, 0, NONE, NONE, 0, 128, 137));
    jobs.push_back(mk(1, 'h010, 1, 'h00, 'h100, 2, 'h00, 1, NONE, NONE, 0, 64, 76));
    jobs.push_back(mk(0, 'h010, 1, 'h00, 'h100, 2, 'h00, 0, NONE, NONE, 0, 0, 1));
    jobs.push_back(mk(1, 'h020, 3, 'h00, 'h080, 1, 'h00, 0, NONE, 10, 0, 64, 73));
    jobs.push_back(mk(1, 'h1F8, 2, 'h00, 'h1FC, 3, 'h00, 0, NONE, NONE, 1, 64, 73));
`ifdef FTRANS_ABORT_EN
    jobs.push_back(mk(1, 'h010, 1, 'h00, 'h100, 2, 'h00, 0, 5, NONE, 0, 6, 15));
`endif
    spots.push_back(sp(0, 0, 'h010, 'h100, 'h01, 0));
    spots.push_back(sp(0, 8, 'h011, 'h100, 'h02, 0));
    spots.push_back(sp(0, 63, 'h017, 'h10E, 'h80, 7));
    spots.push_back(sp(1, 64, 'h050, 'h120, 'h01, 0));
    spots.push_back(sp(1, 127, 'h057, 'h12E, 'h80, 7));
    spots.push_back(sp(2, 3, 'h010, 'h106, 'h01, 3));

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst intr", bus.regmap_ftrans__intr_o, 0);
    chk("rst busy", bus.regmap_ftrans__busy_o, 0);
    chk("rst code", bus.ftransctl_vputy__code_o, 0);
    chk("rst sv_code", bus.ftransctl_vputy__sv_code_o, 6'b000010);
    chk("rst addrs", {bus.ftransctl_vputy__mrs0_addr_o, bus.ftransctl_vputy__mrd_addr_o}, 0);
    chk("rst indices", {bus.ftransctl_vputy__mrs0_index_o, bus.ftransctl_vputy__mrd_index_o}, 0);
    chk("rst mtx_sel", bus.ftransctl_vputy__mtx_sel_h_o, 0);
    chk("rst strobe", bus.ftransctl_vputy__strobe_h_o, 1);
    @(posedge clk_i); #1;

    foreach (jobs[i]) run_job(jobs[i], i);

    for (int r = 0; r < 6; r++) begin
      job_t j;
      j = mk($urandom_range(1, 3), $urandom_range(0, AMASK), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, AMASK), $urandom_range(0, 255), $urandom_range(0, 255), 2, NONE, NONE, 0, 0, NONE);
      j.sidx = $urandom_range(0, 31);
      j.didx = $urandom_range(0, 31);
      j.exp_issues = j.sect * N * N;
      run_job(j, 100 + r);
    end

    // Reset in the middle of a running job
    wr(1, 32'h0000_0201); wr(2, 32'd1); wr(3, 32'h010); wr(4, 32'h100); wr(0, 32'h1);
    repeat (11) @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst issuing", bus.ftransctl_vputy__code_o[0], 1);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst sv_code", bus.ftransctl_vputy__sv_code_o, 6'b000010);
    chk("midrst strobe", bus.ftransctl_vputy__strobe_h_o, 1);
    chk("midrst src", bus.ftransctl_vputy__mrs0_addr_o, 0);
    for (int c = 0; c < 100; c++) begin
      chk($sformatf("midrst c%0d code/busy/intr", c),
          {bus.ftransctl_vputy__code_o, bus.regmap_ftrans__busy_o, bus.regmap_ftrans__intr_o}, 0);
      @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end
endmodule
